// File: rtl/lsu_align.sv
// Load/store alignment unit: turns one RV32 load/store into RAM-safe beats
// (word@0, half@0, or bytes), reassembles and extends load data.
module lsu_align #(
   parameter int unsigned MEM_BYTES = 32004
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [2:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_RESP
   } state_t;

   localparam logic [2:0] SZ_BYTE = 3'b000;
   localparam logic [2:0] SZ_HALF = 3'b001;
   localparam logic [2:0] SZ_WORD = 3'b010;

   state_t      state_q, state_d;
   logic [1:0]  beat_q;
   logic        beat_adv;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  size_q;
   logic [1:0]  last_q;
   logic        err_q;
   logic [31:0] buf_q;

   // request decode, evaluated against the live request port
   logic        accept;
   logic [2:0]  req_n;
   logic        req_illegal;
   logic [32:0] req_end;
   logic        req_err;
   logic        req_split;
   logic [2:0]  req_size;
   logic [1:0]  req_last;
   logic        last_beat;
   logic [31:0] cap_data;

   assign accept    = (state_q == S_IDLE) && req_valid;
   assign last_beat = (beat_q == last_q);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      req_n       = 3'd1;
      req_size    = SZ_BYTE;
      req_illegal = 1'b0;
      case (req_funct3[1:0])
         2'b00:   req_n = 3'd1;
         2'b01:   req_n = 3'd2;
         2'b10:   req_n = 3'd4;
         default: req_illegal = 1'b1;
      endcase
      if (req_funct3 == 3'b110 || req_funct3 == 3'b111) req_illegal = 1'b1;
      if (req_we && req_funct3[2]) req_illegal = 1'b1;

      req_end   = {1'b0, req_addr} + 33'(req_n) - 33'd1;
      req_err   = req_illegal || (req_end >= 33'(MEM_BYTES));
      req_split = (req_n != 3'd1) && (req_addr[1:0] != 2'b00);
      req_last  = req_split ? 2'(req_n - 3'd1) : 2'd0;
      if (!req_split) begin
         if (req_n == 3'd4)      req_size = SZ_WORD;
         else if (req_n == 3'd2) req_size = SZ_HALF;
      end
   end

   always_comb begin
      state_d  = state_q;
      beat_adv = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) state_d = req_err ? S_RESP : S_ISSUE;
         end
         S_ISSUE: begin
            if (!we_q) begin
               state_d = S_CAPTURE;
            end else if (last_beat) begin
               state_d = S_RESP;
            end else begin
               beat_adv = 1'b1;
            end
         end
         S_CAPTURE: begin
            if (last_beat) begin
               state_d = S_RESP;
            end else begin
               state_d  = S_ISSUE;
               beat_adv = 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         beat_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         if (accept)        beat_q <= 2'd0;
         else if (beat_adv) beat_q <= beat_q + 2'd1;
      end
   end

   // RAM returns full lanes; keep only the bytes this beat asked for
   always_comb begin
      cap_data = mem_rdata;
      case (size_q)
         SZ_BYTE: cap_data = {24'd0, mem_rdata[7:0]};
         SZ_HALF: cap_data = {16'd0, mem_rdata[15:0]};
         default: cap_data = mem_rdata;
      endcase
   end

   // NOTE: request datapath is not reset; it is only observed after an accept reloads it.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q     <= req_we;
         funct3_q <= req_funct3;
         addr_q   <= req_addr;
         wdata_q  <= req_wdata;
         size_q   <= req_size;
         last_q   <= req_last;
         err_q    <= req_err;
         buf_q    <= 32'd0;
      end else if (state_q == S_CAPTURE) begin
         buf_q <= buf_q | (cap_data << {beat_q, 3'b000});
      end
   end

   always_comb begin
      req_ready  = (state_q == S_IDLE);
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 32'd0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_size   = 3'd0;
      mem_addr   = 32'd0;
      mem_wdata  = 32'd0;

      if (state_q == S_ISSUE) begin
         mem_read  = !we_q;
         mem_write = we_q;
         mem_size  = size_q;
         mem_addr  = addr_q + {30'd0, beat_q};
         if (we_q) begin
            if (size_q == SZ_BYTE) mem_wdata = {24'd0, 8'(wdata_q >> {beat_q, 3'b000})};
            else                   mem_wdata = wdata_q;
         end
      end

      if (state_q == S_RESP) begin
         resp_valid = 1'b1;
         resp_err   = err_q;
         if (!err_q && !we_q) begin
            case (funct3_q)
               3'b000:  resp_rdata = {{24{buf_q[7]}}, buf_q[7:0]};
               3'b100:  resp_rdata = {24'd0, buf_q[7:0]};
               3'b001:  resp_rdata = {{16{buf_q[15]}}, buf_q[15:0]};
               3'b101:  resp_rdata = {16'd0, buf_q[15:0]};
               default: resp_rdata = buf_q;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: directed test-plan steps, a mid-store
// reset, then random requests checked against a byte-array reference model.
module tb_lsu_align;

   localparam int MEM = 32004;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] ram     [MEM];
   logic [7:0] ref_mem [MEM];
   bit         ram_init = 1'b0;

   lsu_align #(.MEM_BYTES(MEM)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_size   (mem_size),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 7 + 13) ^ (i >> 3));
   endfunction

   // Byte-addressed RAM with a registered read port returning four bytes from addr
   always @(posedge clk) begin : ram_p
      int a;
      int sz;
      if (!ram_init) begin
         for (int i = 0; i < MEM; i++) ram[i] = init_byte(i);
         ram_init = 1'b1;
      end
      a  = int'(mem_addr % 32'(MEM));
      sz = (mem_size == 3'b010) ? 4 : (mem_size == 3'b001) ? 2 : 1;
      if (mem_write)
         for (int i = 0; i < sz; i++) ram[(a + i) % MEM] = mem_wdata[8*i +: 8];
      if (mem_read)
         mem_rdata <= {ram[(a + 3) % MEM], ram[(a + 2) % MEM], ram[(a + 1) % MEM], ram[a]};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1 - 32'd1);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_mem_strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
      check({tag, "_mem_fields"}, {29'd0, mem_size} | mem_addr | mem_wdata, 32'd0);
      check({tag, "_resp_fields"}, 32'(resp_err) | resp_rdata, 32'd0);
   endtask

   // Drive one request, observe beats and response, and compare with the model.
   // Called and returns one time unit after a rising edge with the DUT idle.
   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] o_rd,
                          output logic o_err, output int o_lat);
      int          n;
      bit          e_err;
      bit          split;
      int          beats;
      int          e_lat;
      logic [31:0] v;
      logic [31:0] e_rd;
      logic [31:0] e_a;
      logic [2:0]  e_sz;
      logic [31:0] e_wd;
      int          nb;
      bit          bad_beat;
      bit          conflict;
      bit          ready_bad;
      bit          got;

      n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      e_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) ||
              (longint'(addr) + longint'(n) - 1 >= longint'(MEM));
      split = (n > 1) && (addr[1:0] != 2'b00);
      beats = e_err ? 0 : (split ? n : 1);
      e_lat = e_err ? 1 : (we ? beats + 1 : 2 * beats + 1);
      e_rd  = 32'd0;
      if (!e_err && !we) begin
         v = 32'd0;
         for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
         case (f3)
            3'd0:    e_rd = 32'(signed'(v[7:0]));
            3'd4:    e_rd = 32'(v[7:0]);
            3'd1:    e_rd = 32'(signed'(v[15:0]));
            3'd5:    e_rd = 32'(v[15:0]);
            default: e_rd = v;
         endcase
      end

      check("ready_before", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;

      nb = 0; bad_beat = 0; conflict = 0; ready_bad = 0; got = 0;
      o_rd = 32'hDEAD_BEEF; o_err = 1'bx; o_lat = -1;
      for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
         if (req_ready) ready_bad = 1;
         if (mem_read && mem_write) conflict = 1;
         if (mem_read || mem_write) begin
            if (nb >= beats) begin
               bad_beat = 1;
            end else begin
               e_a  = split ? addr + 32'(nb) : addr;
               e_sz = split ? 3'd0 : (n == 4) ? 3'd2 : (n == 2) ? 3'd1 : 3'd0;
               e_wd = (e_sz == 3'd0) ? {24'd0, wd[8*nb +: 8]} : wd;
               if (mem_addr !== e_addr_fix(e_a) || mem_size !== e_sz ||
                   mem_write !== we || mem_read !== !we) bad_beat = 1;
               if (we && mem_wdata !== e_wd) bad_beat = 1;
            end
            nb++;
         end
         if (resp_valid) begin
            got   = 1;
            o_lat = cyc;
            o_rd  = resp_rdata;
            o_err = resp_err;
         end
         @(posedge clk);
         #1;
      end

      check("resp_seen", 32'(got), 32'd1);
      check("latency", 32'(o_lat), 32'(e_lat));
      check("resp_err", 32'(o_err), 32'(e_err));
      check("resp_rdata", o_rd, e_rd);
      check("beat_count", 32'(nb), 32'(beats));
      check("beat_shape_bad", 32'(bad_beat), 32'd0);
      check("rd_wr_overlap", 32'(conflict), 32'd0);
      check("ready_low_busy", 32'(ready_bad), 32'd0);
      check("ready_after", {31'd0, req_ready}, 32'd1);
      check("no_extra_resp", 32'(resp_valid), 32'd0);

      if (we && !e_err)
         for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
   endtask

   function automatic logic [31:0] e_addr_fix(input logic [31:0] a);
      return a;
   endfunction

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          mism;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] ad;

      for (int i = 0; i < MEM; i++) ref_mem[i] = init_byte(i);
      resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check_quiet("reset");
      resetn = 1'b1;
      @(posedge clk);
      #1;
      check("ready_post_reset", 32'(req_ready), 32'd1);

      // Word loads / byte loads on a preloaded word
      run_req(1'b1, 3'b010, 32'h10, 32'h8899_AABB, rd, er, lat);
      check("sw10_lat", 32'(lat), 32'd2);
      run_req(1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat);
      check("lw10_rdata", rd, 32'h8899_AABB);
      check("lw10_lat", 32'(lat), 32'd3);
      run_req(1'b0, 3'b000, 32'h13, 32'd0, rd, er, lat);
      check("lb13_rdata", rd, 32'hFFFF_FF88);
      run_req(1'b0, 3'b100, 32'h13, 32'd0, rd, er, lat);
      check("lbu13_rdata", rd, 32'h0000_0088);

      // Misaligned word load across a word boundary
      run_req(1'b1, 3'b010, 32'h20, 32'h4433_2211, rd, er, lat);
      run_req(1'b1, 3'b010, 32'h24, 32'h8877_6655, rd, er, lat);
      run_req(1'b0, 3'b010, 32'h23, 32'd0, rd, er, lat);
      check("lw23_rdata", rd, 32'h7766_5544);
      check("lw23_lat", 32'(lat), 32'd9);

      // Misaligned halfword store then loads
      run_req(1'b1, 3'b001, 32'h12, 32'h0000_BEEF, rd, er, lat);
      check("sh12_lat", 32'(lat), 32'd3);
      run_req(1'b0, 3'b101, 32'h12, 32'd0, rd, er, lat);
      check("lhu12_rdata", rd, 32'h0000_BEEF);
      run_req(1'b0, 3'b001, 32'h12, 32'd0, rd, er, lat);
      check("lh12_rdata", rd, 32'hFFFF_BEEF);

      // Errors: out of range store and illegal funct3
      run_req(1'b1, 3'b010, 32'(MEM - 2), 32'h1234_5678, rd, er, lat);
      check("sw_oor_err", 32'(er), 32'd1);
      check("sw_oor_ram", 32'(ram[MEM-2]), 32'(init_byte(MEM - 2)));
      run_req(1'b0, 3'b011, 32'h10, 32'd0, rd, er, lat);
      check("f3_011_err", 32'(er), 32'd1);
      check("f3_011_lat", 32'(lat), 32'd1);
      run_req(1'b1, 3'b000, 32'(MEM - 1), 32'h0000_005A, rd, er, lat);
      check("sb_last_ok", 32'(er), 32'd0);

      // Reset during the second beat of a misaligned store
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h21; req_wdata = 32'hA1B2_C3D4;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("rst_beat0_addr", mem_addr, 32'h21);
      check("rst_beat0_wdata", mem_wdata, 32'h0000_00D4);
      check("rst_beat0_resp", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1;
      check("rst_beat1_addr", mem_addr, 32'h22);
      check("rst_beat1_wdata", mem_wdata, 32'h0000_00C3);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      check_quiet("midrst");
      @(posedge clk);
      #1;
      resetn = 1'b1;
      mism = 0;
      for (int i = 0; i < 4; i++) begin
         if (resp_valid || !req_ready || mem_write) mism++;
         @(posedge clk);
         #1;
      end
      check("midrst_idle", 32'(mism), 32'd0);
      check("midrst_b21", 32'(ram[32'h21]), 32'h0000_00D4);
      check("midrst_b22", 32'(ram[32'h22]), 32'h0000_00C3);
      check("midrst_b23", 32'(ram[32'h23]), 32'h0000_0044);
      ref_mem[32'h21] = 8'hD4;
      ref_mem[32'h22] = 8'hC3;
      run_req(1'b0, 3'b010, 32'h20, 32'd0, rd, er, lat);
      check("midrst_lw20", rd, 32'h44C3_D411);

      // Random traffic against the reference model
      for (int t = 0; t < 80; t++) begin
         we = 1'($urandom);
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) ad = 32'(MEM - 6) + 32'($urandom_range(0, 5));
         else                            ad = 32'($urandom_range(0, 63));
         run_req(we, f3, ad, $urandom, rd, er, lat);
      end

      mism = 0;
      for (int i = 0; i < MEM; i++) if (ram[i] !== ref_mem[i]) mism++;
      check("ram_final", 32'(mism), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit between the core's execute stage and the data RAM. It accepts one RV32 load or store request at a time and issues only access shapes the RAM serves correctly: word at offset 0, halfword at offset 0, or bytes at any offset. Misaligned halfword and word accesses are split into sequential byte beats, and load bytes are reassembled. It sign- or zero-extends load results, range-checks addresses, and returns a single-cycle response.

## Interface
- MEM_BYTES, 32004: size of the data RAM in bytes; the highest legal byte address is MEM_BYTES-1.
- clk  in  1  system clock; everything is on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  1  the core presents a request.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high at a clock edge.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse; the request is complete. There is no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; set for an illegal funct3 or an out-of-range access.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mem_size  out  3  000 byte, 001 halfword, 010 word.
- mem_addr  out  32  RAM byte address.
- mem_wdata  out  32  RAM write data, right-aligned.
- mem_rdata  in  32  RAM read data. The RAM registers it, so it is valid on the cycle after mem_read.

## Operation
- On accept, the block latches we, funct3, addr and wdata, and computes the request size N: 1, 2 or 4 bytes.
- Error checks run on accept:
  - funct3 in {011, 110, 111}, or a store with funct3 of 100 or 101, is illegal.
  - An access is out of range when addr+N-1 (computed 33 bits wide) is at or above MEM_BYTES.
  - On error the block goes straight to RESP with resp_err=1 and issues no memory strobe.
- Beat plan:
  - N=4 with addr[1:0]=00: one word beat.
  - N=2 with addr[1:0]=00: one halfword beat.
  - N=1: one byte beat.
  - Every other case: N byte beats, with beat k addressing addr+k for k=0..N-1. Beats may cross a word boundary.
- States:
  - IDLE: goes to ISSUE on accept, or to RESP on error.
  - ISSUE: drives one beat.
    - A store goes to the next ISSUE, or to RESP after the last beat.
    - A load goes to CAPTURE.
  - CAPTURE: latches mem_rdata (masked to the beat size) into the assembly buffer at byte lane k. It then goes to the next ISSUE, or to RESP after the last beat.
  - RESP: pulses resp_valid, then returns to IDLE.
- Store beats:
  - For a byte beat k, mem_wdata[7:0] = wdata byte k and the upper bits are 0.
  - For a single halfword or word beat, mem_wdata = wdata.
- Load result at RESP, using the assembled value v:
  - LB: sign-extend v[7:0].
  - LBU: zero-extend v[7:0].
  - LH: sign-extend v[15:0].
  - LHU: zero-extend v[15:0].
  - LW: v.
- mem_read and mem_write are never high in the same cycle. Both are 0 outside ISSUE.

## Timing
- Reset values while resetn=0 at an edge:
  - State goes to IDLE and the beat counter is cleared.
  - req_ready=1 on the following cycle.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_read=0, mem_write=0, mem_size=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation abandons the request with no response. Store beats already written remain in the RAM.
- Cycle 0 is the accept edge. Cycle numbers below are the cycles in which resp_valid is high:
  - Single-beat load: resp in cycle 3.
  - N-beat load: resp in cycle 2N+1 (cycle 9 for a 4-byte split).
  - Single-beat store: resp in cycle 2.
  - N-beat store: resp in cycle N+1.
  - Error: resp in cycle 1.
- req_ready is low from cycle 1 through the resp cycle and returns high the cycle after resp.
- Back-to-back throughput: one request every (latency+1) cycles.

## Test plan
- Word preload 0x8899AABB at byte address 0x10:
  - LW 0x10 → one word beat with mem_size=010; resp in cycle 3 with rdata=0x8899AABB and err=0.
  - LB 0x13 → one byte beat; rdata=0xFFFFFF88. LBU 0x13 → rdata=0x00000088.
- Word preloads 0x44332211 at 0x20 and 0x88776655 at 0x24, then LW 0x23 → four byte beats at 0x23, 0x24, 0x25 and 0x26; resp in cycle 9 with rdata=0x77665544.
- SH 0x12 with wdata=0x0000BEEF, then LHU 0x12 → the store issues byte beats at 0x12 (0xEF) and 0x13 (0xBE) with resp in cycle 3; the load returns rdata=0x0000BEEF. LH 0x12 returns 0xFFFFBEEF.
- SW at MEM_BYTES-2, and separately funct3=011 → each gives resp in cycle 1 with err=1, no mem_read or mem_write pulse, and RAM contents unchanged.
- Deassert resetn during beat 2 of a misaligned SW 0x21 with wdata 0xA1B2C3D4 → no resp_valid. Bytes 0x21=0xD4 and 0x22=0xC3 are written and 0x23 is unchanged. req_ready=1 after reset, and a following LW 0x20 completes normally.
